// File: rtl/ctrl_pipe_if.sv
// Control-word bundle between the decode stage and the EX/MEM/WB control pipe.
// The decode side (master) drives the ID word and flush; the pipe (slave) returns stage controls.
interface ctrl_pipe_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_wb;
  logic             id_alu;
  logic             id_mr;
  logic             id_mw;
  logic             id_aluop;
  logic             id_imm;
  logic [REG_W-1:0] id_rd;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs2_en;
  logic             flush;
  logic             stall;
  logic             ex_valid;
  logic             ex_alu;
  logic             ex_aluop;
  logic             ex_imm;
  logic             ex_mr;
  logic             ex_wb;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid;
  logic             mem_mr;
  logic             mem_mw;
  logic             mem_wb;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid;
  logic             wb_we;
  logic [REG_W-1:0] wb_rd;
  logic             wb_from_mem;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_wb, id_alu, id_mr, id_mw, id_aluop, id_imm,
    output id_rd, id_rs1, id_rs2, id_rs2_en, flush,
    input  stall,
    input  ex_valid, ex_alu, ex_aluop, ex_imm, ex_mr, ex_wb, ex_rd,
    input  mem_valid, mem_mr, mem_mw, mem_wb, mem_rd,
    input  wb_valid, wb_we, wb_rd, wb_from_mem, bubble_cnt
  );

  modport slave (
    input  id_valid, id_wb, id_alu, id_mr, id_mw, id_aluop, id_imm,
    input  id_rd, id_rs1, id_rs2, id_rs2_en, flush,
    output stall,
    output ex_valid, ex_alu, ex_aluop, ex_imm, ex_mr, ex_wb, ex_rd,
    output mem_valid, mem_mr, mem_mw, mem_wb, mem_rd,
    output wb_valid, wb_we, wb_rd, wb_from_mem, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control pipe: carries the decoded control word through EX/MEM/WB, inserts
// load-use bubbles, honours branch flushes and counts hazard bubbles.
module ctrl_pipe #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             wb;
    logic             alu;
    logic             mr;
    logic             mw;
    logic             aluop;
    logic             imm;
    logic [REG_W-1:0] rd;
  } stage_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  stage_t           stage_q [3];
  stage_t           stage_d [3];
  stage_t           id_word;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic             haz;
  logic             ex_load;

  // A load in EX is identified by valid & MR & WB; only that stage can stall decode.
  assign ex_load = stage_q[EX].valid & stage_q[EX].mr & stage_q[EX].wb;
  assign haz     = bus.id_valid & ex_load &
                   ((stage_q[EX].rd == bus.id_rs1) |
                    (bus.id_rs2_en & (stage_q[EX].rd == bus.id_rs2)));
  assign bus.stall = haz & ~bus.flush;

  always_comb begin
    id_word       = '0;
    id_word.valid = bus.id_valid;
    id_word.wb    = bus.id_wb;
    id_word.alu   = bus.id_alu;
    id_word.mr    = bus.id_mr;
    id_word.mw    = bus.id_mw;
    id_word.aluop = bus.id_aluop;
    id_word.imm   = bus.id_imm;
    id_word.rd    = bus.id_rd;

    stage_d[EX]  = (bus.flush || haz) ? '0 : id_word;
    stage_d[MEM] = stage_q[EX];
    stage_d[WB]  = stage_q[MEM];

    bubble_cnt_d = bubble_cnt_q;
    if (bus.stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        stage_q[i] <= '0;
      end
      bubble_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        stage_q[i] <= stage_d[i];
      end
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Flags and rd are gated with valid so an invalid or bubble slot reads all-zero.
  assign bus.ex_valid    = stage_q[EX].valid;
  assign bus.ex_alu      = stage_q[EX].valid & stage_q[EX].alu;
  assign bus.ex_aluop    = stage_q[EX].valid & stage_q[EX].aluop;
  assign bus.ex_imm      = stage_q[EX].valid & stage_q[EX].imm;
  assign bus.ex_mr       = stage_q[EX].valid & stage_q[EX].mr;
  assign bus.ex_wb       = stage_q[EX].valid & stage_q[EX].wb;
  assign bus.ex_rd       = {REG_W{stage_q[EX].valid}} & stage_q[EX].rd;

  assign bus.mem_valid   = stage_q[MEM].valid;
  assign bus.mem_mr      = stage_q[MEM].valid & stage_q[MEM].mr;
  assign bus.mem_mw      = stage_q[MEM].valid & stage_q[MEM].mw;
  assign bus.mem_wb      = stage_q[MEM].valid & stage_q[MEM].wb;
  assign bus.mem_rd      = {REG_W{stage_q[MEM].valid}} & stage_q[MEM].rd;

  assign bus.wb_valid    = stage_q[WB].valid;
  assign bus.wb_we       = stage_q[WB].valid & stage_q[WB].wb;
  assign bus.wb_rd       = {REG_W{stage_q[WB].valid}} & stage_q[WB].rd;
  assign bus.wb_from_mem = stage_q[WB].valid & stage_q[WB].mr;

  assign bus.bubble_cnt  = bubble_cnt_q;

endmodule
